// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer parameter loader: command codes,
// payload length, field widths and the frame-parser state encoding.
package synth_pkg;

  localparam logic [7:0] CMD_WRITE_PARAMS = 8'h01;
  localparam logic [7:0] CMD_START        = 8'h02;

  localparam int PAYLOAD_LEN = 13;

  localparam int SIGNAL_TYPE_W = 2;
  localparam int F_CARRIER_W   = 32;
  localparam int T_IMPULSE_W   = 10;
  localparam int T_PERIOD_W    = 13;
  localparam int NUM_OF_IMP_W  = 5;
  localparam int DEVIATION_W   = 22;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    PAYLOAD,
    CHECK
  } state_e;

endpackage

// File: rtl/synth_frame_timeout.sv
// Inter-byte timeout: reloadable down-counter. Every received byte reloads
// it; while a frame is in progress it counts down and flags expiry when it
// sits at zero and no byte arrives (an arriving byte always wins).
module synth_frame_timeout #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on a byte, otherwise decrement toward zero while active
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && !load && (cnt_q == '0);

endmodule

// File: rtl/synth_param_loader.sv
// Frame parser and committed parameter store for digital_synthesizer_v1.
// Frames: HEADER, CMD, PAYLOAD[n], CHK (CHK = XOR of CMD and payload).
// Payload lands in a shadow set; outputs change only on a verified commit.
// Optional build macro SYNTH_PARAM_RANGE_CHECK_EN rejects WRITE_PARAMS frames
// whose parameters are unusable (zero width/count, width >= period, type 3).
module synth_param_loader
  import synth_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_VALID,
  output logic                     SIGN_START_GEN,
  output logic [SIGNAL_TYPE_W-1:0] SIGNAL_TYPE,
  output logic [F_CARRIER_W-1:0]   F_CARRIER,
  output logic [T_IMPULSE_W-1:0]   T_IMPULSE,
  output logic [T_PERIOD_W-1:0]    T_PERIOD,
  output logic [NUM_OF_IMP_W-1:0]  NUM_OF_IMP,
  output logic [DEVIATION_W-1:0]   DEVIATION,
  output logic                     PARAM_VALID,
  output logic                     FRAME_OK,
  output logic                     FRAME_ERR
);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] xor_q, xor_d;
  logic       is_write_q, is_write_d;

  // Shadow set, filled byte by byte from the payload
  logic [SIGNAL_TYPE_W-1:0] sh_type_q, sh_type_d;
  logic [F_CARRIER_W-1:0]   sh_fc_q, sh_fc_d;
  logic [T_IMPULSE_W-1:0]   sh_timp_q, sh_timp_d;
  logic [T_PERIOD_W-1:0]    sh_tper_q, sh_tper_d;
  logic [NUM_OF_IMP_W-1:0]  sh_num_q, sh_num_d;
  logic [DEVIATION_W-1:0]   sh_dev_q, sh_dev_d;

  // Committed set and output flags
  logic [SIGNAL_TYPE_W-1:0] type_q, type_d;
  logic [F_CARRIER_W-1:0]   fc_q, fc_d;
  logic [T_IMPULSE_W-1:0]   timp_q, timp_d;
  logic [T_PERIOD_W-1:0]    tper_q, tper_d;
  logic [NUM_OF_IMP_W-1:0]  num_q, num_d;
  logic [DEVIATION_W-1:0]   dev_q, dev_d;
  logic pvalid_q, pvalid_d;
  logic ok_q, ok_d;
  logic err_q, err_d;
  logic start_q, start_d;

  logic tmo_expired;
  logic range_bad;

  synth_frame_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .load    (RX_VALID),
    .run     (state_q != IDLE),
    .expired (tmo_expired)
  );

`ifdef SYNTH_PARAM_RANGE_CHECK_EN
  assign range_bad = (sh_timp_q == '0) || (sh_num_q == '0) ||
                     ({3'b000, sh_timp_q} >= sh_tper_q) || (sh_type_q == 2'b11);
`else
  assign range_bad = 1'b0;
`endif

  // Frame parser: next state, shadow assembly, commit and result pulses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    is_write_d = is_write_q;
    sh_type_d  = sh_type_q;
    sh_fc_d    = sh_fc_q;
    sh_timp_d  = sh_timp_q;
    sh_tper_d  = sh_tper_q;
    sh_num_d   = sh_num_q;
    sh_dev_d   = sh_dev_q;
    type_d     = type_q;
    fc_d       = fc_q;
    timp_d     = timp_q;
    tper_d     = tper_q;
    num_d      = num_q;
    dev_d      = dev_q;
    pvalid_d   = pvalid_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    start_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_VALID && (RX_DATA == HEADER_BYTE)) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (RX_VALID) begin
          xor_d = RX_DATA;
          cnt_d = '0;
          if (RX_DATA == CMD_WRITE_PARAMS) begin
            is_write_d = 1'b1;
            state_d    = PAYLOAD;
          end else if (RX_DATA == CMD_START) begin
            is_write_d = 1'b0;
            state_d    = CHECK;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (RX_VALID) begin
          xor_d = xor_q ^ RX_DATA;
          cnt_d = cnt_q + 4'd1;
          case (cnt_q)
            4'd0:  sh_type_d         = RX_DATA[1:0];
            4'd1:  sh_fc_d[31:24]    = RX_DATA;
            4'd2:  sh_fc_d[23:16]    = RX_DATA;
            4'd3:  sh_fc_d[15:8]     = RX_DATA;
            4'd4:  sh_fc_d[7:0]      = RX_DATA;
            4'd5:  sh_timp_d[9:8]    = RX_DATA[1:0];
            4'd6:  sh_timp_d[7:0]    = RX_DATA;
            4'd7:  sh_tper_d[12:8]   = RX_DATA[4:0];
            4'd8:  sh_tper_d[7:0]    = RX_DATA;
            4'd9:  sh_num_d          = RX_DATA[4:0];
            4'd10: sh_dev_d[21:16]   = RX_DATA[5:0];
            4'd11: sh_dev_d[15:8]    = RX_DATA;
            4'd12: sh_dev_d[7:0]     = RX_DATA;
            default: ;
          endcase
          if (cnt_q == 4'(PAYLOAD_LEN - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (RX_VALID) begin
          state_d = IDLE;
          if (RX_DATA != xor_q) begin
            err_d = 1'b1;
          end else if (is_write_q) begin
            if (range_bad) begin
              err_d = 1'b1;
            end else begin
              type_d   = sh_type_q;
              fc_d     = sh_fc_q;
              timp_d   = sh_timp_q;
              tper_d   = sh_tper_q;
              num_d    = sh_num_q;
              dev_d    = sh_dev_q;
              pvalid_d = 1'b1;
              ok_d     = 1'b1;
            end
          end else if (pvalid_q) begin
            start_d = 1'b1;
            ok_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Silence mid-frame abandons the frame; the shadow set is simply never used
    if (tmo_expired) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  // State, shadow and committed registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      xor_q      <= '0;
      is_write_q <= 1'b0;
      sh_type_q  <= '0;
      sh_fc_q    <= '0;
      sh_timp_q  <= '0;
      sh_tper_q  <= '0;
      sh_num_q   <= '0;
      sh_dev_q   <= '0;
      type_q     <= '0;
      fc_q       <= '0;
      timp_q     <= '0;
      tper_q     <= '0;
      num_q      <= '0;
      dev_q      <= '0;
      pvalid_q   <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      is_write_q <= is_write_d;
      sh_type_q  <= sh_type_d;
      sh_fc_q    <= sh_fc_d;
      sh_timp_q  <= sh_timp_d;
      sh_tper_q  <= sh_tper_d;
      sh_num_q   <= sh_num_d;
      sh_dev_q   <= sh_dev_d;
      type_q     <= type_d;
      fc_q       <= fc_d;
      timp_q     <= timp_d;
      tper_q     <= tper_d;
      num_q      <= num_d;
      dev_q      <= dev_d;
      pvalid_q   <= pvalid_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      start_q    <= start_d;
    end
  end

  assign SIGN_START_GEN = start_q;
  assign SIGNAL_TYPE    = type_q;
  assign F_CARRIER      = fc_q;
  assign T_IMPULSE      = timp_q;
  assign T_PERIOD       = tper_q;
  assign NUM_OF_IMP     = num_q;
  assign DEVIATION      = dev_q;
  assign PARAM_VALID    = pvalid_q;
  assign FRAME_OK       = ok_q;
  assign FRAME_ERR      = err_q;

endmodule

// File: tb/tb_synth_param_loader.sv
// Bench for synth_param_loader: directed frames with literal expectations,
// then randomized frames checked every cycle against a frame-level model.
module tb_synth_param_loader;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        SIGN_START_GEN;
  logic [1:0]  SIGNAL_TYPE;
  logic [31:0] F_CARRIER;
  logic [9:0]  T_IMPULSE;
  logic [12:0] T_PERIOD;
  logic [4:0]  NUM_OF_IMP;
  logic [21:0] DEVIATION;
  logic        PARAM_VALID;
  logic        FRAME_OK;
  logic        FRAME_ERR;

  synth_param_loader #(
    .TIMEOUT_CYCLES (TMO),
    .HEADER_BYTE    (8'hA5)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .RX_DATA        (RX_DATA),
    .RX_VALID       (RX_VALID),
    .SIGN_START_GEN (SIGN_START_GEN),
    .SIGNAL_TYPE    (SIGNAL_TYPE),
    .F_CARRIER      (F_CARRIER),
    .T_IMPULSE      (T_IMPULSE),
    .T_PERIOD       (T_PERIOD),
    .NUM_OF_IMP     (NUM_OF_IMP),
    .DEVIATION      (DEVIATION),
    .PARAM_VALID    (PARAM_VALID),
    .FRAME_OK       (FRAME_OK),
    .FRAME_ERR      (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0]  mframe[$];
  bit          m_in = 0;
  int          m_silent = 0;
  logic [1:0]  e_st = 0;
  logic [31:0] e_fc = 0;
  logic [9:0]  e_ti = 0;
  logic [12:0] e_tp = 0;
  logic [4:0]  e_n = 0;
  logic [21:0] e_dv = 0;
  bit e_pv = 0, e_ok = 0, e_err = 0, e_start = 0;

  initial begin
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        m_in = 0; m_silent = 0; mframe.delete();
        e_st = 0; e_fc = 0; e_ti = 0; e_tp = 0; e_n = 0; e_dv = 0;
        e_pv = 0; e_ok = 0; e_err = 0; e_start = 0;
      end else begin
        e_ok = 0; e_err = 0; e_start = 0;
        if (RX_VALID) begin
          m_silent = 0;
          if (!m_in) begin
            if (RX_DATA == 8'hA5) begin
              m_in = 1;
              mframe.delete();
            end
          end else begin
            mframe.push_back(RX_DATA);
            if (mframe.size() == 1 && mframe[0] != 8'h01 && mframe[0] != 8'h02) begin
              e_err = 1; m_in = 0;
            end else begin
              int need;
              need = (mframe[0] == 8'h01) ? 15 : 2;
              if (mframe.size() == need) begin
                logic [7:0] x;
                x = 0;
                for (int i = 0; i < need - 1; i++) x ^= mframe[i];
                m_in = 0;
                if (x != mframe[need-1]) begin
                  e_err = 1;
                end else if (mframe[0] == 8'h01) begin
                  logic [1:0] st; logic [9:0] ti; logic [12:0] tp; logic [4:0] n;
                  bit bad;
                  st = mframe[1][1:0];
                  ti = {mframe[6][1:0], mframe[7]};
                  tp = {mframe[8][4:0], mframe[9]};
                  n  = mframe[10][4:0];
                  bad = 0;
`ifdef SYNTH_PARAM_RANGE_CHECK_EN
                  bad = (ti == 0) || (n == 0) || (int'(ti) >= int'(tp)) || (st == 2'd3);
`endif
                  if (bad) begin
                    e_err = 1;
                  end else begin
                    e_st = st; e_ti = ti; e_tp = tp; e_n = n;
                    e_fc = {mframe[2], mframe[3], mframe[4], mframe[5]};
                    e_dv = {mframe[11][5:0], mframe[12], mframe[13]};
                    e_pv = 1; e_ok = 1;
                  end
                end else if (e_pv) begin
                  e_start = 1; e_ok = 1;
                end else begin
                  e_err = 1;
                end
              end
            end
          end
        end else if (m_in) begin
          m_silent++;
          if (m_silent == TMO) begin
            e_err = 1; m_in = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (RESET_N) begin
        cmp("m_start", 32'(SIGN_START_GEN), 32'(e_start));
        cmp("m_type",  32'(SIGNAL_TYPE),    32'(e_st));
        cmp("m_fc",    F_CARRIER,           e_fc);
        cmp("m_timp",  32'(T_IMPULSE),      32'(e_ti));
        cmp("m_tper",  32'(T_PERIOD),       32'(e_tp));
        cmp("m_num",   32'(NUM_OF_IMP),     32'(e_n));
        cmp("m_dev",   32'(DEVIATION),      32'(e_dv));
        cmp("m_pv",    32'(PARAM_VALID),    32'(e_pv));
        cmp("m_ok",    32'(FRAME_OK),       32'(e_ok));
        cmp("m_err",   32'(FRAME_ERR),      32'(e_err));
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  logic [7:0] pl[$];

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int n, input logic [7:0] flip, input bit gaps);
    logic [7:0] x;
    x = cmd;
    send_byte(8'hA5);
    if (gaps) idle($urandom_range(0, 2));
    send_byte(cmd);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(pl[i]);
      x ^= pl[i];
    end
    if (gaps) idle($urandom_range(0, 2));
    send_byte(x ^ flip);
  endtask

  task automatic build_payload(input logic [1:0] st, input logic [31:0] fc, input logic [9:0] ti,
                               input logic [12:0] tp, input logic [4:0] n, input logic [21:0] dv,
                               input bit junk);
    logic [31:0] j;
    j = junk ? $urandom : 32'h0;
    pl.delete();
    pl.push_back({j[7:2], st});
    pl.push_back(fc[31:24]); pl.push_back(fc[23:16]);
    pl.push_back(fc[15:8]);  pl.push_back(fc[7:0]);
    pl.push_back({j[15:10], ti[9:8]}); pl.push_back(ti[7:0]);
    pl.push_back({j[23:21], tp[12:8]}); pl.push_back(tp[7:0]);
    pl.push_back({j[31:29], n});
    pl.push_back({j[9:8], dv[21:16]}); pl.push_back(dv[15:8]); pl.push_back(dv[7:0]);
  endtask

  task automatic load_directed();
    pl = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h64,
           8'h01, 8'hF4, 8'h05, 8'h03, 8'h0D, 8'h40};
  endtask

  initial begin
    logic [7:0] x;
    // Reset state
    repeat (3) @(negedge CLK);
    cmp("rst_fc", F_CARRIER, 32'h0);
    cmp("rst_pv", 32'(PARAM_VALID), 32'h0);
    cmp("rst_err", 32'(FRAME_ERR), 32'h0);
    RESET_N = 1'b1;
    idle(1);

    // START with no parameters committed
    send_frame(8'h02, 0, 8'h00, 0);
    cmp("start_noparam_err", 32'(FRAME_ERR), 32'h1);
    cmp("start_noparam_gen", 32'(SIGN_START_GEN), 32'h0);
    idle(1);

    // Reference WRITE_PARAMS frame
    load_directed();
    send_frame(8'h01, 13, 8'h00, 0);
    cmp("wr_ok",   32'(FRAME_OK), 32'h1);
    cmp("wr_type", 32'(SIGNAL_TYPE), 32'h1);
    cmp("wr_fc",   F_CARRIER, 32'h00100000);
    cmp("wr_timp", 32'(T_IMPULSE), 32'd100);
    cmp("wr_tper", 32'(T_PERIOD), 32'd500);
    cmp("wr_num",  32'(NUM_OF_IMP), 32'd5);
    cmp("wr_dev",  32'(DEVIATION), 32'h030D40);
    cmp("wr_pv",   32'(PARAM_VALID), 32'h1);
    idle(1);
    cmp("wr_ok_once", 32'(FRAME_OK), 32'h0);

    // START after commit: one-cycle pulse
    send_frame(8'h02, 0, 8'h00, 0);
    cmp("start_gen", 32'(SIGN_START_GEN), 32'h1);
    cmp("start_ok", 32'(FRAME_OK), 32'h1);
    idle(1);
    cmp("start_gen_once", 32'(SIGN_START_GEN), 32'h0);

    // Corrupted checksum
    pl[3] = 8'h77;
    send_frame(8'h01, 13, 8'h01, 0);
    cmp("badchk_err", 32'(FRAME_ERR), 32'h1);
    cmp("badchk_keep", F_CARRIER, 32'h00100000);

    // Noise then unknown command
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    cmp("noise_no_err", 32'(FRAME_ERR), 32'h0);
    send_byte(8'h07);
    cmp("badcmd_err", 32'(FRAME_ERR), 32'h1);
    send_frame(8'h02, 0, 8'h00, 0);
    cmp("badcmd_idle_ok", 32'(FRAME_OK), 32'h1);

    // Timeout after five payload bytes
    load_directed();
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(pl[i]);
    idle(TMO - 1);
    cmp("tmo_early", 32'(FRAME_ERR), 32'h0);
    idle(1);
    cmp("tmo_err", 32'(FRAME_ERR), 32'h1);
    cmp("tmo_keep", 32'(T_IMPULSE), 32'd100);
    idle(2);

    // Byte coinciding with expiry wins; frame then completes normally
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(pl[i]);
    idle(TMO - 1);
    send_byte(pl[5]);
    cmp("tmo_coincide_no_err", 32'(FRAME_ERR), 32'h0);
    x = 8'h01;
    for (int i = 0; i < 13; i++) x ^= pl[i];
    for (int i = 6; i < 13; i++) send_byte(pl[i]);
    send_byte(x);
    cmp("tmo_coincide_ok", 32'(FRAME_OK), 32'h1);

    // T_IMPULSE equal to T_PERIOD
    build_payload(2'd1, 32'h12345678, 10'd500, 13'd500, 5'd5, 22'h1, 0);
    send_frame(8'h01, 13, 8'h00, 0);
`ifdef SYNTH_PARAM_RANGE_CHECK_EN
    cmp("range_err", 32'(FRAME_ERR), 32'h1);
    cmp("range_keep", 32'(T_IMPULSE), 32'd100);
`else
    cmp("range_ok", 32'(FRAME_OK), 32'h1);
    cmp("range_commit", 32'(T_IMPULSE), 32'd500);
`endif

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        logic [9:0] ti; logic [12:0] tp;
        ti = 10'($urandom_range(1, 1000));
        tp = 13'($urandom_range(int'(ti) + 1, 8191));
        build_payload(2'($urandom_range(0, 2)), $urandom, ti, tp,
                      5'($urandom_range(1, 31)), 22'($urandom), 1);
        send_frame(8'h01, 13, 8'h00, 1);
      end else if (r <= 3) begin
        build_payload(2'($urandom), $urandom, 10'($urandom), 13'($urandom),
                      5'($urandom), 22'($urandom), 1);
        send_frame(8'h01, 13, 8'h00, 1);
      end else if (r <= 5) begin
        send_frame(8'h02, 0, 8'h00, 1);
      end else if (r == 6) begin
        build_payload(2'($urandom), $urandom, 10'($urandom), 13'($urandom),
                      5'($urandom), 22'($urandom), 1);
        send_frame(8'h01, 13, 8'($urandom_range(1, 255)), 1);
      end else if (r == 7) begin
        send_byte(8'hA5);
        send_byte(8'($urandom_range(3, 255)));
      end else if (r == 8) begin
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom_range(0, 8'hA4)));
      end else begin
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat ($urandom_range(0, 12)) send_byte(8'($urandom));
        idle(TMO + 1);
      end
      idle($urandom_range(0, 2));
    end
    idle(TMO + 2);

    // Asynchronous reset in the middle of a payload
    load_directed();
    send_frame(8'h01, 13, 8'h00, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(pl[i]);
    #2;
    RESET_N = 1'b0;
    #1;
    cmp("arst_fc", F_CARRIER, 32'h0);
    cmp("arst_timp", 32'(T_IMPULSE), 32'h0);
    cmp("arst_pv", 32'(PARAM_VALID), 32'h0);
    cmp("arst_type", 32'(SIGNAL_TYPE), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(1);
    send_frame(8'h02, 0, 8'h00, 0);
    cmp("arst_start_err", 32'(FRAME_ERR), 32'h1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
